// File: rtl/vreg_seq_pkg.sv
// Shared types and helpers for the vector-register read sequencer.
package vreg_seq_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'b00,
    SEW16   = 2'b01,
    SEW32   = 2'b10,
    SEW_ILL = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_e;

  // Elements of one register group held by a lane; an illegal SEW holds none.
  function automatic int cap_f(sew_e sew, logic [1:0] lmul, int loc_per_lane);
    if (sew == SEW_ILL) return 0;
    return (loc_per_lane << (2 - int'(sew))) << lmul;
  endfunction

endpackage

// File: rtl/vreg_read_sequencer_if.sv
// Request, counter-control and element-strobe bundle between a lane's read
// sequencer (slave) and its surroundings (master).
interface vreg_read_sequencer_if #(
  parameter int MEM_DEPTH         = 512,
  parameter int VREG_LOC_PER_LANE = 16,
  parameter int VLANE_NUM         = 8
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int SW = 32 - $clog2(VLANE_NUM * 4);
  localparam int CW = $clog2(VREG_LOC_PER_LANE * 4 * 8) + 1;

  logic            req_valid_i;
  logic            req_ready_o;
  logic [4:0]      req_vs_i;
  logic [1:0]      req_lmul_i;
  logic [1:0]      req_sew_i;
  logic [CW-1:0]   req_vl_i;
  logic [SW-1:0]   req_slide_i;
  logic            req_dir_i;
  logic            kill_i;
  logic            rd_ready_i;
  logic [8*AW-1:0] start_addr_o;
  logic [SW-1:0]   slide_offset_o;
  logic            load_o;
  logic            rst_cnt_o;
  logic            en_o;
  logic [1:0]      element_width_o;
  logic            up_down_o;
  logic            el_valid_o;
  logic            el_last_o;
  logic            done_o;

  modport master (
    output req_valid_i, req_vs_i, req_lmul_i, req_sew_i, req_vl_i,
           req_slide_i, req_dir_i, kill_i, rd_ready_i,
    input  req_ready_o, start_addr_o, slide_offset_o, load_o, rst_cnt_o,
           en_o, element_width_o, up_down_o, el_valid_o, el_last_o, done_o
  );

  modport slave (
    input  req_valid_i, req_vs_i, req_lmul_i, req_sew_i, req_vl_i,
           req_slide_i, req_dir_i, kill_i, rd_ready_i,
    output req_ready_o, start_addr_o, slide_offset_o, load_o, rst_cnt_o,
           en_o, element_width_o, up_down_o, el_valid_o, el_last_o, done_o
  );

endinterface

// File: rtl/vreg_seq_delay_pipe.sv
// Fixed-depth shift of {valid,last} that lines element strobes up with the
// VRF read data; synchronous flush drops everything in flight.
module vreg_seq_delay_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic valid,
  input  logic last,
  output logic dly_valid,
  output logic dly_last
);

  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] last_sr;

  // NOTE: these stages are reset and flushable because a stale valid bit would surface as a phantom element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else if (flush) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else begin
      valid_sr[0] <= valid;
      last_sr[0]  <= valid & last;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end
    end
  end

  assign dly_valid = valid_sr[DEPTH-1];
  assign dly_last  = last_sr[DEPTH-1];

endmodule

// File: rtl/vreg_read_sequencer.sv
// Per-lane VRF read sequencer: captures one request, drives the address counter
// one element per cycle, delays strobes by the read latency. Option: VREG_SEQ_REVERSE_EN.
module vreg_read_sequencer
  import vreg_seq_pkg::*;
#(
  parameter int MEM_DEPTH         = 512,
  parameter int VREG_LOC_PER_LANE = 16,
  parameter int VLANE_NUM         = 8,
  parameter int READ_LATENCY      = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  vreg_read_sequencer_if.slave bus
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int SW = 32 - $clog2(VLANE_NUM * 4);
  localparam int CW = $clog2(VREG_LOC_PER_LANE * 4 * 8) + 1;

  state_e          state, state_n;
  logic            pending;
  logic            accept;
  logic            load;
  logic            en;
  logic            last_in;
  logic            flush;
  logic            done;
  int              cap;
  logic [CW-1:0]   eff_cnt;
  logic [CW-1:0]   remaining;
  logic [8*AW-1:0] start_addr_n;
  logic [8*AW-1:0] start_addr;
  logic [SW-1:0]   slide;
  sew_e            sew;
  logic            dly_valid;
  logic            dly_last;

  always_comb begin
    cap     = cap_f(sew_e'(bus.req_sew_i), bus.req_lmul_i, VREG_LOC_PER_LANE);
    eff_cnt = (int'(bus.req_vl_i) < cap) ? bus.req_vl_i : CW'(cap);
  end

  // Eight consecutive registers starting at vs, wrapping at v31.
  always_comb begin
    start_addr_n = '0;
    for (int i = 0; i < 8; i++) begin
      start_addr_n[i*AW +: AW] =
        AW'(((32'(bus.req_vs_i) + 32'(i)) % 32) * VREG_LOC_PER_LANE);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    last_in = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid_i && bus.req_ready_o) begin
          accept = 1'b1;
          if (eff_cnt != '0) state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_n = bus.kill_i ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        en = bus.rd_ready_i;
        if (en && remaining == CW'(1)) begin
          last_in = 1'b1;
          state_n = ST_IDLE;
        end
        if (bus.kill_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign flush = bus.kill_i && (state != ST_IDLE);

  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      remaining  <= '0;
      start_addr <= '0;
      slide      <= '0;
      sew        <= SEW8;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (accept && eff_cnt == '0) || (dly_valid && dly_last);
      if (accept) begin
        pending    <= 1'b1;
        remaining  <= eff_cnt;
        start_addr <= start_addr_n;
        slide      <= bus.req_slide_i;
        sew        <= sew_e'(bus.req_sew_i);
      end else begin
        if (done || flush) pending <= 1'b0;
        if (en) remaining <= remaining - CW'(1);
      end
    end
  end

`ifdef VREG_SEQ_REVERSE_EN
  logic up_down;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       up_down <= 1'b1;
    else if (accept) up_down <= bus.req_dir_i;
  end

  assign bus.up_down_o = up_down;
`else
  logic unused_dir;

  assign unused_dir    = bus.req_dir_i;
  assign bus.up_down_o = 1'b1;
`endif

  vreg_seq_delay_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_pipe (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush),
    .valid     (en),
    .last      (last_in),
    .dly_valid (dly_valid),
    .dly_last  (dly_last)
  );

  // The pipe keeps draining after RUN, so readiness also waits for done.
  assign bus.req_ready_o     = (state == ST_IDLE) && !pending;
  assign bus.start_addr_o    = start_addr;
  assign bus.slide_offset_o  = slide;
  assign bus.load_o          = load;
  assign bus.rst_cnt_o       = load;
  assign bus.en_o            = en;
  assign bus.element_width_o = sew;
  assign bus.el_valid_o      = dly_valid;
  assign bus.el_last_o       = dly_last;
  assign bus.done_o          = done;

endmodule

// File: tb/tb_vreg_read_sequencer.sv
// Scoreboard bench for vreg_read_sequencer: stimulus queues expected element
// and done events, a negedge monitor pops and compares them.
module tb_vreg_read_sequencer;
  import vreg_seq_pkg::*;

  localparam int AW  = 9;
  localparam int SW  = 27;
  localparam int CW  = 10;
  localparam int LAT = 2;

  typedef struct {
    bit zero;
    int acc;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vreg_read_sequencer_if bus_if ();

  vreg_read_sequencer #(
    .MEM_DEPTH         (512),
    .VREG_LOC_PER_LANE (16),
    .VLANE_NUM         (8),
    .READ_LATENCY      (LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  int        checks      = 0;
  int        errors      = 0;
  int        cyc         = 0;
  int        last_el_cyc = -100;
  int        done_cyc    = -100;
  bit        exp_el_q[$];
  done_exp_t exp_done_q[$];
  int        en_cyc_q[$];
  bit        mon_last;
  done_exp_t mon_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every element strobe and every done pulse consumes an expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.en_o) en_cyc_q.push_back(cyc);
      if (bus_if.el_valid_o) begin
        check("el_expected", exp_el_q.size() > 0, 1);
        check("el_has_en", en_cyc_q.size() > 0, 1);
        if (exp_el_q.size() > 0) begin
          mon_last = exp_el_q.pop_front();
          check("el_last", bus_if.el_last_o, mon_last);
          if (mon_last) last_el_cyc = cyc;
        end
        if (en_cyc_q.size() > 0) check("el_latency", cyc - en_cyc_q.pop_front(), LAT);
      end
      if (bus_if.done_o) begin
        done_cyc = cyc;
        check("done_expected", exp_done_q.size() > 0, 1);
        if (exp_done_q.size() > 0) begin
          mon_d = exp_done_q.pop_front();
          check("done_cycle", cyc, mon_d.zero ? mon_d.acc + 1 : last_el_cyc + 1);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic run_req(input string nm, input int vs, input int lmul, input int sew,
                         input int vl, input int slide, input bit dir, input bit toggle,
                         input int kill_run, input int exp_cnt, input int exp_span,
                         input int exp_elems, input int e0, input int e1, input int e2,
                         input int e3);
    int acc, kill_cyc, n_en, n_load, n_rst, first_en, last_en;
    bit got, fin;
    int exp_ud;
`ifdef VREG_SEQ_REVERSE_EN
    exp_ud = int'(dir);
`else
    exp_ud = 1;
`endif
    bus_if.req_vs_i    = 5'(vs);
    bus_if.req_lmul_i  = 2'(lmul);
    bus_if.req_sew_i   = 2'(sew);
    bus_if.req_vl_i    = CW'(vl);
    bus_if.req_slide_i = SW'(slide);
    bus_if.req_dir_i   = dir;
    bus_if.rd_ready_i  = 1'b1;
    bus_if.req_valid_i = 1'b1;
    got = 0;
    acc = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus_if.req_ready_o) begin
        got = 1;
        acc = cyc;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check({nm, "_accept"}, got, 1);
    if (got) begin
      for (int i = 0; i < exp_elems; i++) exp_el_q.push_back(kill_run == 0 && i == exp_elems - 1);
      if (kill_run == 0) exp_done_q.push_back('{zero: (exp_cnt == 0), acc: acc});
    end
    @(posedge clk);
    #1;
    bus_if.req_valid_i = 1'b0;
    if (!got) return;
    kill_cyc = (kill_run > 0) ? acc + 1 + kill_run : -1;
    n_en = 0; n_load = 0; n_rst = 0; first_en = -1; last_en = -1; fin = 0;
    for (int i = 0; i < 1500 && !fin; i++) begin
      if (toggle) bus_if.rd_ready_i = ((cyc - (acc + 2)) % 2 == 0);
      bus_if.kill_i = (cyc == kill_cyc);
      @(negedge clk);
      if (cyc == acc + 1) begin
        check({nm, "_ready_busy"}, bus_if.req_ready_o, 0);
        check({nm, "_addr0"}, bus_if.start_addr_o[0*AW +: AW], e0);
        check({nm, "_addr1"}, bus_if.start_addr_o[1*AW +: AW], e1);
        check({nm, "_addr2"}, bus_if.start_addr_o[2*AW +: AW], e2);
        check({nm, "_addr3"}, bus_if.start_addr_o[3*AW +: AW], e3);
        check({nm, "_slide"}, bus_if.slide_offset_o, slide);
        check({nm, "_ew"}, bus_if.element_width_o, sew);
        check({nm, "_up_down"}, bus_if.up_down_o, exp_ud);
      end
      if (bus_if.en_o) begin
        if (n_en == 0) first_en = cyc;
        last_en = cyc;
        n_en++;
      end
      if (bus_if.load_o) n_load++;
      if (bus_if.rst_cnt_o) n_rst++;
      if (bus_if.req_ready_o) begin
        fin = 1;
        if (kill_run > 0) begin
          check({nm, "_kill_ready_cycle"}, cyc, kill_cyc + 1);
          check({nm, "_kill_en"}, bus_if.en_o, 0);
        end else begin
          check({nm, "_ready_after_done"}, cyc, done_cyc + 1);
        end
      end
      @(posedge clk);
      #1;
    end
    bus_if.kill_i     = 1'b0;
    bus_if.rd_ready_i = 1'b1;
    check({nm, "_finished"}, fin, 1);
    check({nm, "_en_count"}, n_en, exp_cnt);
    check({nm, "_load_count"}, n_load, (exp_cnt > 0) ? 1 : 0);
    check({nm, "_rst_cnt_count"}, n_rst, (exp_cnt > 0) ? 1 : 0);
    if (exp_cnt > 0) begin
      check({nm, "_first_en"}, first_en - acc, 2);
      check({nm, "_en_span"}, last_en - first_en, exp_span);
    end
    if (kill_run > 0) begin
      en_cyc_q.delete();
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus_if.req_valid_i = 1'b0;
    bus_if.req_vs_i    = '0;
    bus_if.req_lmul_i  = '0;
    bus_if.req_sew_i   = '0;
    bus_if.req_vl_i    = '0;
    bus_if.req_slide_i = '0;
    bus_if.req_dir_i   = 1'b1;
    bus_if.kill_i      = 1'b0;
    bus_if.rd_ready_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", bus_if.req_ready_o, 1);
    check("rst_up_down", bus_if.up_down_o, 1);
    check("rst_en", bus_if.en_o, 0);
    check("rst_load", bus_if.load_o, 0);
    check("rst_el_valid", bus_if.el_valid_o, 0);
    check("rst_done", bus_if.done_o, 0);
    check("rst_start_addr", bus_if.start_addr_o, 0);
    @(posedge clk);
    #1;

    //       name       vs lmul sew  vl  slide dir tog kill cnt span elems addr0..3
    run_req("basic",     3, 0,  2,  16,  5,    1,  0,  0,   16, 15,  16,  48, 64, 80, 96);
    run_req("clip",      0, 1,  0, 200,  0,    1,  0,  0,  128, 127, 128,  0, 16, 32, 48);
    run_req("vl0",       7, 0,  2,   0,  0,    1,  0,  0,    0,  0,   0, 112, 128, 144, 160);
    run_req("sew_ill",   9, 0,  3,  10,  0,    1,  0,  0,    0,  0,   0, 144, 160, 176, 192);
    run_req("toggle",    2, 0,  2,   8,  0,    1,  1,  0,    8, 14,   8,  32, 48, 64, 80);
    run_req("kill",      1, 0,  2,  16,  0,    1,  0,  5,    5,  4,   3,  16, 32, 48, 64);
    run_req("wrap",     30, 3,  2,  20,  7,    0,  0,  0,   20, 19,  20, 480, 496, 0, 16);

    repeat (5) @(posedge clk);
    #1;
    check("el_queue_drained", exp_el_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vreg_read_sequencer.md
Name: vreg_read_sequencer

Overview:
- Upstream control stage for one lane's vector-register-file read address counter.
- Accepts one read request per instruction: source register, LMUL, SEW, per-lane element count, slide offset.
- Drives the counter's start_addr/slide_offset/load/rst_cnt/en/element_width/up_down inputs, one element per cycle under downstream backpressure.
- Delays valid/last by the BRAM read latency so the data consumer receives element strobes aligned with read data.

Parameters:
- MEM_DEPTH, 512, VRF words per lane; AW = $clog2(MEM_DEPTH).
- VREG_LOC_PER_LANE, 16, words per vector register per lane.
- VLANE_NUM, 8, lane count; sets slide offset width SW = 32-$clog2(VLANE_NUM*4).
- READ_LATENCY, 2, cycles from en_o to read data valid (legal range 1..4).
- CW, $clog2(VREG_LOC_PER_LANE*4*8)+1, element count width (10 at defaults).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- req_vs_i  in  5  source vector register.
- req_lmul_i  in  2  log2 LMUL (0..3).
- req_sew_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_vl_i  in  CW  elements for this lane.
- req_slide_i  in  SW  slide offset.
- req_dir_i  in  1  1 ascending, 0 descending (macro-gated).
- kill_i  in  1  abort current request.
- rd_ready_i  in  1  downstream can accept one element this cycle.
- start_addr_o  out  8*AW  packed per-register base addresses.
- slide_offset_o  out  SW  captured slide offset.
- load_o  out  1  address counter load strobe.
- rst_cnt_o  out  1  address counter reset strobe.
- en_o  out  1  address counter advance.
- element_width_o  out  2  captured SEW.
- up_down_o  out  1  captured direction.
- el_valid_o  out  1  read data valid (en_o delayed READ_LATENCY).
- el_last_o  out  1  marks final element, aligned with el_valid_o.
- done_o  out  1  one-cycle pulse when request retires.

Behaviour:
- Reset values: all outputs 0 except req_ready_o=1 and up_down_o=1. State = IDLE; delay pipes cleared.
- FSM IDLE -> LOAD -> RUN -> IDLE.
  - IDLE: handshake on req_valid_i & req_ready_o captures all req_* fields.
  - Next state is LOAD, unless effective count is 0 or SEW=11; then stay in IDLE and pulse done_o next cycle with no element strobes.
- Start addresses: entry i (i=0..7) = ((req_vs_i+i) mod 32)*VREG_LOC_PER_LANE, truncated to AW. Computed at capture and held stable until the next capture.
- Effective count: min(req_vl_i, cap), where cap = (VREG_LOC_PER_LANE << (2-sew)) << lmul. Remaining-count register is loaded with this value.
- LOAD: exactly one cycle. load_o=1, rst_cnt_o=1, en_o=0. Then go to RUN.
- RUN:
  - en_o = rd_ready_i; remaining decrements on each en_o.
  - When en_o is high and remaining==1: the last flag enters the delay pipe, the state returns to IDLE, and done_o pulses when that last flag exits the pipe.
- req_ready_o:
  - Deasserted from the capture cycle until the cycle after done_o, so at most one request is in flight, including the pipe.
  - Back-to-back requests are therefore separated by READ_LATENCY+1 cycles.
- Pipe: el_valid_o/el_last_o are a READ_LATENCY-deep shift of en_o/last. Not stalled by rd_ready_i, since downstream ready gates en_o and no data is in flight without a slot.
- kill_i (any non-IDLE state): next cycle state=IDLE, en_o=0, pipe flushed, no done_o. kill_i in IDLE is ignored. kill_i and req_valid_i in the same IDLE cycle: the request is accepted.
- Asynchronous reset mid-run: immediate return to reset values; in-flight elements are discarded.

Optional Feature:
- Macro VREG_SEQ_REVERSE_EN.
- Defined: req_dir_i is captured; up_down_o follows the captured value; element order and count are unchanged.
- Undefined: req_dir_i is ignored and up_down_o is tied to 1.

Decomposition:
- Package vreg_seq_pkg: sew_e enum (SEW8/SEW16/SEW32/SEW_ILL), state_e enum, and function cap_f(sew,lmul,VREG_LOC_PER_LANE).
- One sub-module: vreg_seq_delay_pipe. Parameterised-depth shift of {valid,last} with synchronous flush and async reset.

Test Plan:
- vs=3, lmul=0, sew=10, vl=16, rd_ready=1 -> start_addr entry0=48, entry1=64. LOAD 1 cycle, then en_o 16 consecutive cycles. el_valid 16 cycles starting 2 cycles later. el_last on the 16th. done_o 1 cycle after the last el_valid.
- sew=00, lmul=1, vl=200 -> clipped to cap 128: exactly 128 en_o pulses.
- vl=0, or sew=11 -> no load_o/en_o; done_o pulses 1 cycle after accept.
- rd_ready_i toggling 1010… with vl=8 -> 8 en_o pulses across 15 RUN cycles; element count exact; last aligned.
- kill_i asserted on the 5th RUN cycle -> en_o low next cycle, no further el_valid, no done_o; req_ready_o=1 the cycle after kill.
- vs=30, lmul=3 -> start_addr entries wrap: entry2=0, entry3=16. With VREG_SEQ_REVERSE_EN defined and dir=0 -> up_down_o=0.
